// File: rtl/led_actor_pkg.sv
// Shared definitions for the LED actor: sequencer state encoding and
// default frame geometry.
package led_actor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    DELAY     = 2'd2,
    START     = 2'd3
  } seq_state_t;

  localparam int DEFAULT_LED_COUNT   = 60;
  localparam int DEFAULT_RAM_LATENCY = 4;

endpackage

// File: rtl/edge_detector.sv
// Optional input synchroniser followed by a registered single-edge detector.
// RISING selects rising (1) or falling (0) edges. The pulse appears
// SYNC_STAGES+1 cycles after the input changes.
module edge_detector #(
  parameter int SYNC_STAGES = 0,
  parameter bit RISING      = 1'b1
) (
  input  logic clock_12mhz,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic synced;
  logic hist;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw input through the synchroniser chain.
      always_ff @(posedge clock_12mhz) begin
        if (reset) begin
          sync_q <= {SYNC_STAGES{din}};
        end else begin
          sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Keep one sample of history and register the edge pulse.
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      // NOTE: history (and the sync chain) preload the live input during reset
      // instead of a constant, so leaving reset never looks like an edge.
      hist  <= din;
      pulse <= 1'b0;
    end else begin
      hist  <= synced;
      pulse <= RISING ? (synced & ~hist) : (~synced & hist);
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame/pixel timing core: walks led_index across a frame on each LED tick
// and fires encoder_start RAM_LATENCY clocks after the tick, once all
// encoders are ready. Flags ticks and frame edges that arrive too early.
module led_frame_sequencer
  import led_actor_pkg::*;
#(
  parameter int LED_COUNT   = DEFAULT_LED_COUNT,
  parameter int IDX_W       = $clog2(LED_COUNT),
  parameter int RAM_LATENCY = DEFAULT_RAM_LATENCY,
  parameter int CHANNELS    = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic                clock_12mhz,
  input  logic                reset,
  input  logic                framerate,
  input  logic                led_clock,
  input  logic [CHANNELS-1:0] encoder_ready,
  output logic                led_clock_rising_edge,
  output logic                frame_start,
  output logic [IDX_W-1:0]    led_index,
  output logic [CHANNELS-1:0] encoder_start,
  output logic                frame_done,
  output logic                frame_active,
  output logic                tick_overrun,
  output logic                frame_overrun
);

  localparam int CNT_W = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_COUNT - 1);

  seq_state_t       state, state_n;
  logic [CNT_W-1:0] delay_cnt, cnt_n;
  logic [IDX_W-1:0] index_n;
  logic             active_n, start_n, done_n, tick_ovr_n, frame_ovr_n;
  logic             start_fire;
  logic             frame_edge;
  logic             tick;

  edge_detector #(.SYNC_STAGES(SYNC_STAGES), .RISING(1'b0)) u_frame_edge (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .din         (framerate),
    .pulse       (frame_edge)
  );

  edge_detector #(.SYNC_STAGES(SYNC_STAGES), .RISING(1'b1)) u_tick_edge (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .din         (led_clock),
    .pulse       (led_clock_rising_edge)
  );

  assign tick          = led_clock_rising_edge;
  assign encoder_start = {CHANNELS{start_fire}};

  // Next-state, next-index and pulse decisions; a frame edge overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n     = state;
    cnt_n       = delay_cnt;
    index_n     = led_index;
    active_n    = frame_active;
    start_n     = 1'b0;
    done_n      = 1'b0;
    tick_ovr_n  = 1'b0;
    frame_ovr_n = 1'b0;
    start_fire  = 1'b0;

    if (frame_edge) begin
      start_n     = 1'b1;
      frame_ovr_n = frame_active;
      index_n     = '0;
      cnt_n       = '0;
      active_n    = 1'b1;
      state_n     = WAIT_TICK;
    end else begin
      case (state)
        IDLE: begin
        end
        WAIT_TICK: begin
          if (tick) begin
            if (RAM_LATENCY == 1) begin
              state_n = START;
            end else begin
              cnt_n   = CNT_W'(1);
              state_n = DELAY;
            end
          end
        end
        DELAY: begin
          tick_ovr_n = tick;
          if (delay_cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = START;
          end else begin
            cnt_n = delay_cnt + CNT_W'(1);
          end
        end
        START: begin
          tick_ovr_n = tick;
          if (&encoder_ready) begin
            start_fire = 1'b1;
            if (led_index == IDX_LAST) begin
              done_n   = 1'b1;
              active_n = 1'b0;
              state_n  = IDLE;
            end else begin
              index_n = led_index + IDX_W'(1);
              state_n = WAIT_TICK;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, index, delay counter and registered pulse outputs.
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state         <= IDLE;
      delay_cnt     <= '0;
      led_index     <= '0;
      frame_active  <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      tick_overrun  <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state         <= state_n;
      delay_cnt     <= cnt_n;
      led_index     <= index_n;
      frame_active  <= active_n;
      frame_start   <= start_n;
      frame_done    <= done_n;
      tick_overrun  <= tick_ovr_n;
      frame_overrun <= frame_ovr_n;
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench: two sequencers (SYNC_STAGES 0 and 2) share directed
// and random stimulus and are compared every cycle against a deadline-based
// reference model computed from the raw input history.
module tb_led_frame_sequencer;

  localparam int N  = 4;
  localparam int RL = 4;

  logic       clock_12mhz;
  logic       reset;
  logic       framerate;
  logic       led_clock;
  logic [1:0] encoder_ready;

  logic       d0_rise, d0_fs, d0_fd, d0_fa, d0_to, d0_fo;
  logic [1:0] d0_idx, d0_enc;
  logic       d2_rise, d2_fs, d2_fd, d2_fa, d2_to, d2_fo;
  logic [1:0] d2_idx, d2_enc;

  led_frame_sequencer #(.LED_COUNT(N), .RAM_LATENCY(RL), .CHANNELS(2), .SYNC_STAGES(0)) dut0 (
    .clock_12mhz(clock_12mhz), .reset(reset), .framerate(framerate), .led_clock(led_clock),
    .encoder_ready(encoder_ready), .led_clock_rising_edge(d0_rise), .frame_start(d0_fs),
    .led_index(d0_idx), .encoder_start(d0_enc), .frame_done(d0_fd), .frame_active(d0_fa),
    .tick_overrun(d0_to), .frame_overrun(d0_fo));

  led_frame_sequencer #(.LED_COUNT(N), .RAM_LATENCY(RL), .CHANNELS(2), .SYNC_STAGES(2)) dut2 (
    .clock_12mhz(clock_12mhz), .reset(reset), .framerate(framerate), .led_clock(led_clock),
    .encoder_ready(encoder_ready), .led_clock_rising_edge(d2_rise), .frame_start(d2_fs),
    .led_index(d2_idx), .encoder_start(d2_enc), .frame_done(d2_fd), .frame_active(d2_fa),
    .tick_overrun(d2_to), .frame_overrun(d2_fo));

  initial clock_12mhz = 1'b0;
  always #5 clock_12mhz = ~clock_12mhz;

  int cyc = 0;
  always @(posedge clock_12mhz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Raw input history, one entry per cycle.
  bit lc_h [0:8191];
  bit fr_h [0:8191];
  bit rst_h[0:8191];

  function automatic bit sample(input int i, input bit is_frame);
    return is_frame ? fr_h[i] : lc_h[i];
  endfunction

  // Value of input sample j as seen at edge p: a reset between them replaces
  // older samples with the one present when that reset was taken.
  function automatic bit eff(input int j, input int p, input bit is_frame);
    for (int r = p - 1; r >= j + 1; r--)
      if (rst_h[r-1]) return sample(r - 1, is_frame);
    return sample(j, is_frame);
  endfunction

  function automatic bit edge_at(input int p, input int s, input bit is_frame);
    bit nv, ov;
    if (rst_h[p-1]) return 1'b0;
    nv = eff(p - 1 - s, p, is_frame);
    ov = eff(p - 2 - s, p, is_frame);
    return is_frame ? (!nv && ov) : (nv && !ov);
  endfunction

  typedef struct {
    bit active;
    int idx;
    bit pend;
    int start_at;
    bit fs, fd, to, fo;
  } model_t;

  model_t m[2];

  task automatic evaluate(input int k, input int c, input logic rise, input logic fs,
                          input logic [1:0] idx, input logic [1:0] enc, input logic fd,
                          input logic fa, input logic to, input logic fo);
    int     s;
    bit     tk, fe, fire;
    model_t cur, n;
    s    = (k == 0) ? 0 : 2;
    tk   = edge_at(c, s, 1'b0);
    fe   = edge_at(c, s, 1'b1);
    cur  = m[k];
    fire = !fe && cur.active && cur.pend && (c >= cur.start_at) && (encoder_ready == 2'b11);
    check($sformatf("S%0d.led_clock_rising_edge", s), 32'(rise), 32'(tk));
    check($sformatf("S%0d.frame_start", s), 32'(fs), 32'(cur.fs));
    check($sformatf("S%0d.led_index", s), 32'(idx), cur.idx);
    check($sformatf("S%0d.encoder_start", s), 32'(enc), fire ? 32'd3 : 32'd0);
    check($sformatf("S%0d.frame_done", s), 32'(fd), 32'(cur.fd));
    check($sformatf("S%0d.frame_active", s), 32'(fa), 32'(cur.active));
    check($sformatf("S%0d.tick_overrun", s), 32'(to), 32'(cur.to));
    check($sformatf("S%0d.frame_overrun", s), 32'(fo), 32'(cur.fo));

    n    = cur;
    n.fs = 1'b0;
    n.fd = 1'b0;
    n.to = 1'b0;
    n.fo = 1'b0;
    if (reset) begin
      n = '{default: 0};
    end else if (fe) begin
      n.fs     = 1'b1;
      n.fo     = cur.active;
      n.idx    = 0;
      n.active = 1'b1;
      n.pend   = 1'b0;
    end else if (cur.active) begin
      if (!cur.pend) begin
        if (tk) begin
          n.pend     = 1'b1;
          n.start_at = c + RL;
        end
      end else begin
        n.to = tk;
        if (fire) begin
          n.pend = 1'b0;
          if (cur.idx == N - 1) begin
            n.fd     = 1'b1;
            n.active = 1'b0;
          end else begin
            n.idx = cur.idx + 1;
          end
        end
      end
    end
    m[k] = n;
  endtask

  int enc_cnt = 0, fd_cnt = 0, to_cnt = 0, fo_cnt = 0;

  // Record inputs, compare both DUTs with the model, tally SYNC_STAGES=0 pulses.
  always @(negedge clock_12mhz) begin
    lc_h[cyc]  = led_clock;
    fr_h[cyc]  = framerate;
    rst_h[cyc] = reset;
    if (cyc >= 6) begin
      evaluate(0, cyc, d0_rise, d0_fs, d0_idx, d0_enc, d0_fd, d0_fa, d0_to, d0_fo);
      evaluate(1, cyc, d2_rise, d2_fs, d2_idx, d2_enc, d2_fd, d2_fa, d2_to, d2_fo);
      if (d0_enc != 2'b00) enc_cnt++;
      if (d0_fd) fd_cnt++;
      if (d0_to) to_cnt++;
      if (d0_fo) fo_cnt++;
    end else begin
      m[0] = '{default: 0};
      m[1] = '{default: 0};
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock_12mhz);
    #1;
  endtask

  int s_enc, s_fd, s_to, s_fo;

  task automatic snap();
    s_enc = enc_cnt;
    s_fd  = fd_cnt;
    s_to  = to_cnt;
    s_fo  = fo_cnt;
  endtask

  initial begin
    reset         = 1'b1;
    framerate     = 1'b0;
    led_clock     = 1'b1;
    encoder_ready = 2'b11;
    step(6);
    reset = 1'b0;
    step(3);

    // Full frame of four LEDs, ticks 20 cycles apart.
    snap();
    framerate = 1'b1; step(3);
    framerate = 1'b0; step(8);
    for (int i = 0; i < N; i++) begin
      led_clock = 1'b0; step(2);
      led_clock = 1'b1; step(18);
    end
    step(10);
    check("dir.frame_enc_count", enc_cnt - s_enc, 4);
    check("dir.frame_done_count", fd_cnt - s_fd, 1);
    check("dir.frame_no_overrun", (to_cnt - s_to) + (fo_cnt - s_fo), 0);

    // Encoder stall: one channel not ready for a while.
    framerate = 1'b1; step(3);
    framerate = 1'b0; step(8);
    snap();
    led_clock = 1'b0; step(2);
    led_clock = 1'b1; encoder_ready = 2'b01; step(12);
    encoder_ready = 2'b11; step(10);
    check("dir.stall_enc_count", enc_cnt - s_enc, 1);

    // Second tick two cycles after the first.
    snap();
    led_clock = 1'b0; step(1);
    led_clock = 1'b1; step(1);
    led_clock = 1'b0; step(1);
    led_clock = 1'b1; step(20);
    check("dir.overrun_tick_count", to_cnt - s_to, 1);
    check("dir.overrun_enc_count", enc_cnt - s_enc, 1);

    // Frame edge while LED 2 is pending.
    framerate = 1'b1; step(2);
    snap();
    led_clock = 1'b0; step(2);
    led_clock = 1'b1; step(2);
    framerate = 1'b0; step(6);
    check("dir.frame_overrun_count", fo_cnt - s_fo, 1);
    check("dir.abandoned_enc_count", enc_cnt - s_enc, 0);
    snap();
    led_clock = 1'b0; step(2);
    led_clock = 1'b1; step(10);
    check("dir.restart_enc_count", enc_cnt - s_enc, 1);

    // One-cycle reset while the delay is running.
    snap();
    led_clock = 1'b0; step(2);
    led_clock = 1'b1; step(2);
    reset = 1'b1; step(1);
    reset = 1'b0; step(10);
    check("dir.reset_enc_count", enc_cnt - s_enc, 0);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 15) led_clock = ~led_clock;
      if ($urandom_range(0, 59) == 0) framerate = ~framerate;
      encoder_ready = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      reset = ($urandom_range(0, 399) == 0);
      step(1);
    end
    reset = 1'b0;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
